// File: rtl/mem_pkg.sv
// Shared load/store codes (also used by the CPU decoder) and the responder state encoding.
package mem_pkg;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [1:0] ST_SW = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SB = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        MemWrite;
    logic [31:0] MemAdd;
    logic [31:0] MemWriData;
    logic [2:0]  Load;
    logic [1:0]  Store;
    logic        resp_valid;
    logic [31:0] MemRedData;
    logic        resp_err;

    modport master (
        output req_valid, MemWrite, MemAdd, MemWriData, Load, Store,
        input  req_ready, resp_valid, MemRedData, resp_err
    );

    modport slave (
        input  req_valid, MemWrite, MemAdd, MemWriData, Load, Store,
        output req_ready, resp_valid, MemRedData, resp_err
    );

endinterface

// File: rtl/mem_lane.sv
// Byte-lane logic: load extract/extend, store merge, alignment and illegal-code check.
// Purely combinational.
module mem_lane
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic        is_store,
    input  logic [2:0]  load,
    input  logic [1:0]  store,
    output logic [31:0] rdata,
    output logic [31:0] new_word,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_val;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        ld_val   = 32'd0;
        err      = 1'b0;
        if (is_store) begin
            case (store)
                ST_SW:   err = (off != 2'd0);
                ST_SH:   err = off[0];
                ST_SB:   err = 1'b0;
                default: err = 1'b1;
            endcase
        end else begin
            case (load)
                LD_LW: begin
                    ld_val = word;
                    err    = (off != 2'd0);
                end
                LD_LH: begin
                    ld_val = sext16(half_sel);
                    err    = off[0];
                end
                LD_LHU: begin
                    ld_val = {16'd0, half_sel};
                    err    = off[0];
                end
                LD_LB:   ld_val = sext8(byte_sel);
                LD_LBU:  ld_val = {24'd0, byte_sel};
                default: err = 1'b1;
            endcase
        end
        rdata = (is_store || err) ? 32'd0 : ld_val;
    end

    // Only the addressed lanes are replaced; the caller gates the write on err.
    always_comb begin
        new_word = word;
        case (store)
            ST_SW: new_word = wdata;
            ST_SH: begin
                if (off[1]) new_word[31:16] = wdata[15:0];
                else        new_word[15:0]  = wdata[15:0];
            end
            ST_SB:   new_word[{off, 3'b000} +: 8] = wdata[7:0];
            default: new_word = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory: accepts one request in IDLE, waits WAIT_STATES+1 BUSY cycles, pulses resp_valid.
// No response back-pressure; req_ready is low from acceptance until the cycle after the response.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input logic              clk,
    input logic              rstn,
    dmem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    ready_q;
    logic                    resp_valid_q;
    logic [31:0]             rdata_q;
    logic                    err_q;

    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_widx;
    logic [1:0]              r_off;
    logic [31:0]             r_wdata;
    logic [2:0]              r_load;
    logic [1:0]              r_store;

    logic [31:0]             mem [0:DEPTH-1];
    logic [31:0]             cur_word;
    logic [31:0]             lane_rdata;
    logic [31:0]             lane_new;
    logic                    lane_err;
    logic                    access;
    logic                    mem_we;

    // Address bits above the memory size are deliberately dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.MemAdd[31:ADDR_WIDTH+2];

    assign cur_word = mem[r_widx];
    assign access   = (state == BUSY) && (cnt == 4'd0);
    assign mem_we   = access && r_write && !lane_err;

    mem_lane u_lane (
        .word     (cur_word),
        .wdata    (r_wdata),
        .off      (r_off),
        .is_store (r_write),
        .load     (r_load),
        .store    (r_store),
        .rdata    (lane_rdata),
        .new_word (lane_new),
        .err      (lane_err)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            r_write      <= 1'b0;
            r_widx       <= '0;
            r_off        <= 2'd0;
            r_wdata      <= 32'd0;
            r_load       <= 3'd0;
            r_store      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.MemWrite;
                        r_widx  <= bus.MemAdd[ADDR_WIDTH+1:2];
                        r_off   <= bus.MemAdd[1:0];
                        r_wdata <= bus.MemWriData;
                        r_load  <= bus.Load;
                        r_store <= bus.Store;
                        cnt     <= 4'(WAIT_STATES);
                        ready_q <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata_q      <= lane_rdata;
                        err_q        <= lane_err;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; the write is gated by state, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) mem[r_widx] <= lane_new;
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.MemRedData = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves load/store requests from the CPU over a valid/ready request channel and a one-cycle response pulse. It replaces the zero-latency data memory behind the CPU's `MemAdd`/`MemWriData`/`MemRedData` port when the core moves to a stalling, multi-cycle memory interface. It decodes the CPU's `Load`/`Store` codes, performs sub-word lane selection with sign/zero extension, inserts a configurable number of wait states, and flags misaligned or illegal accesses.

## Interface
- `ADDR_WIDTH`, default 10: word-index bits; memory is 2^ADDR_WIDTH × 32-bit words.
- `WAIT_STATES`, default 2: extra busy cycles per access; legal range 0–15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder idle and accepting.
- `MemWrite`  in  1  1 = store, 0 = load.
- `MemAdd`  in  32  byte address.
- `MemWriData`  in  32  store data; the sub-word value sits in the low bits.
- `Load`  in  3  load type: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5–7 illegal.
- `Store`  in  2  store type: 0 SW, 1 SH, 2 SB; 3 illegal.
- `resp_valid`  out  1  one-cycle response pulse.
- `MemRedData`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal access; qualified by `resp_valid`.

## Operation
- Three states:
  - `IDLE`: `req_ready` = 1.
  - `BUSY`: wait-state countdown.
  - `RESP`: `resp_valid` = 1.
- Handshake: a request is accepted at a rising edge where `req_valid & req_ready`.
  - All request fields are captured into internal registers at that edge.
  - Inputs are don't-care afterwards.
- On acceptance: go to `BUSY` with `cnt` = `WAIT_STATES`.
- In `BUSY`:
  - `cnt` ≠ 0: decrement.
  - `cnt` = 0: perform the access at this edge, register the response, go to `RESP`.
- `RESP` always returns to `IDLE` on the next edge. There is no response back-pressure.
- Word index is `MemAdd[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so accesses wrap modulo memory size.
- Lane order is little-endian: `addr[1:0]` = 0 selects bits 7:0, and `addr[1]` = 0 selects halfword 15:0.
- Load extension:
  - LH and LB sign-extend.
  - LHU and LBU zero-extend.
  - LW returns the whole word.
- Stores perform a read-modify-write of the addressed word; only the selected byte lanes change.
- Error conditions:
  - word access with `addr[1:0]` ≠ 0;
  - halfword access with `addr[0]` ≠ 0;
  - illegal `Load` code on a load;
  - illegal `Store` code on a store.
- On error: memory is not modified, `MemRedData` = 0, `resp_err` = 1, and latency is unchanged.
- `Store` is ignored on loads; `Load` is ignored on stores.

## Timing
- Let cycle 0 be the cycle in which the request is accepted.
  - `BUSY` occupies cycles 1 … `WAIT_STATES`+1.
  - `resp_valid` is high in cycle `WAIT_STATES`+2 only.
  - `req_ready` is low from cycle 1 through cycle `WAIT_STATES`+2 and high again in cycle `WAIT_STATES`+3.
- Minimum request spacing is `WAIT_STATES`+3 cycles.
- Store data becomes visible to a load accepted at or after cycle `WAIT_STATES`+3.
- `MemRedData` and `resp_err` are registered and hold their value until the next response. They are stable in the `resp_valid` cycle.
- Reset (asynchronous assert, synchronous-safe deassert):
  - state → `IDLE`, `cnt` = 0;
  - `req_ready` = 1, `resp_valid` = 0, `MemRedData` = 0, `resp_err` = 0;
  - memory contents are not reset.
- Reset mid-operation:
  - The in-flight request is dropped.
  - A store whose access edge has not occurred is not written.
  - No response is issued for the dropped request.
- `req_valid` asserted while `req_ready` = 0 is ignored. The requester must hold the request until accepted.

## Structure
- Shared package `mem_pkg` holds:
  - the `Load` and `Store` code constants, shared with the CPU decoder;
  - the state enum (`IDLE`/`BUSY`/`RESP`).
- Sub-module `mem_lane` is combinational and contains:
  - the load extract/extend path (word, offset, load type → data);
  - the store merge path (old word, new data, offset, store type → new word);
  - the alignment/illegal-code error check.
- `dmem_responder` holds the FSM, counter, request registers and memory array.

## Test plan
- Reset behaviour: with `WAIT_STATES`=2, assert reset, then SW 0x8badf00d to 0x10 and LW 0x10.
  - Required: `resp_valid` exactly in cycle 4 for each request, `resp_err`=0.
  - Required: LW returns 0x8badf00d.
- Sub-word loads: SW 0x80ff7f01 to 0x20, then:
  - LB 0x20 → 0x00000001;
  - LB 0x23 → 0xffffff80;
  - LBU 0x23 → 0x00000080;
  - LH 0x22 → 0xffff80ff;
  - LHU 0x22 → 0x000080ff.
- Sub-word stores: SW 0x11223344 to 0x30, SB 0xaa to 0x31, SH 0xbeef to 0x32.
  - Required: LW 0x30 → 0xbeefaa44.
- Errors:
  - LW 0x42 → `resp_err`=1, data 0.
  - SH 0x41 → `resp_err`=1, and a following LW 0x40 is unchanged.
  - Load=6 → `resp_err`=1.
  - Store=3 → `resp_err`=1.
- Handshake:
  - Hold `req_valid` high continuously → acceptances spaced `WAIT_STATES`+3 cycles apart.
  - `WAIT_STATES`=0 → response in cycle 2.
  - Address 0x1000+0x10 with `ADDR_WIDTH`=10 aliases 0x10.
- Reset mid-store: drop `rstn` in cycle 1 of an SW 0xdeadbeef to 0x50 that was preceded by SW 0 to 0x50.
  - Required: no `resp_valid` is issued.
  - Required: a subsequent LW 0x50 → 0x00000000.
